mux_scan_serializer: RTL
========================

Name: mux_scan_serializer

Overview:
Upstream sequencer for the team's 8:1 data-flow multiplexer. It accepts an 8-bit parallel word over a valid/ready handshake and registers it. It then steps the 3-bit select through all eight positions, one bit per accepted beat. The selected bit is presented as a serial stream with its own valid/ready handshake. The block contains its own 8:1 selection of the held word and also exports the select code.

Parameters:
LSB_FIRST, 1, 1 = emit in[0] first, ascending to in[7]; 0 = emit in[7] first, descending to in[0]

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort; drops current word, returns to IDLE
in_data  input  8  parallel word to serialize
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word this cycle
sel  output  3  current select code (index of bit on ser_out)
ser_out  output  1  current serial bit = held_word[sel]
ser_valid  output  1  ser_out valid
ser_ready  input  1  downstream accepts ser_out this cycle
ser_last  output  1  current beat is the 8th bit of the word
busy  output  1  high in SHIFT state

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n), all state on posedge clk.
- Reset (rst_n=0, immediate):
  - state=IDLE, held_word=8'h00, bit_cnt=0.
  - Outputs: sel=3'b000, ser_out=0, ser_valid=0, ser_last=0, busy=0, in_ready=1.
- States: IDLE, SHIFT.
- IDLE:
  - in_ready=1, ser_valid=0.
  - Load on in_valid & in_ready: held_word<=in_data, bit_cnt<=0, go to SHIFT.
  - First bit is on ser_out with ser_valid=1 the cycle after the load (latency 1).
- SHIFT:
  - ser_valid=1, busy=1.
  - sel = LSB_FIRST ? bit_cnt : 7-bit_cnt.
  - ser_out = held_word[sel], combinational from registers.
  - ser_last = (bit_cnt==7).
- Serial beat (ser_valid & ser_ready):
  - Not last: bit_cnt increments.
  - Last: go to IDLE, unless a new word loads the same cycle.
- Backpressure: with ser_ready=0, sel, ser_out, ser_last and held_word hold stable indefinitely.
- Zero-bubble reload:
  - in_ready = (state==IDLE) | (state==SHIFT & ser_last & ser_ready).
  - If in_valid is high on the last beat: load the new word, bit_cnt<=0, stay in SHIFT. Its first bit appears on the very next cycle.
- in_valid in SHIFT before the last beat is ignored (in_ready=0); the word is not captured.
- in_data is sampled only on the load edge; later changes do not affect the word in flight.
- bit_cnt is 3 bits and never wraps inside a word; the last beat always ends the word.
- flush=1:
  - Next state=IDLE, bit_cnt=0, ser_valid=0 next cycle. held_word is left unchanged.
  - Overrides a simultaneous load and the last-beat transition.
  - in_ready is forced 0 while flush=1.
- Reset mid-word aborts immediately; no partial word is resumed.
- In IDLE, sel shows the start index (0 if LSB_FIRST, else 7) and ser_out shows held_word[sel] with ser_valid=0. Downstream ignores both.
- Throughput: 8 cycles per word with ser_ready held high and in_valid continuous.

Test Plan:
- Reset: rst_n=0 mid-word (3 bits sent) -> immediately sel=0, ser_valid=0, busy=0, in_ready=1. After release, idle until in_valid.
- Basic LSB_FIRST: load 8'b10101010, ser_ready=1 -> 1 cycle later, 8 beats with sel=0..7 and ser_out=0,1,0,1,0,1,0,1. ser_last only on sel=7; then IDLE.
- MSB_FIRST (LSB_FIRST=0): load 8'b11001010, ser_ready=1 -> sel=7..0, ser_out=1,1,0,0,1,0,1,0.
- Backpressure: load 8'hA5, drop ser_ready for 3 cycles at bit_cnt=4 -> sel=4 and ser_out=0 held stable. Resume yields remaining bits 0,1,0,1; 8 beats total.
- Back-to-back: words 8'hF0 then 8'h0F, in_valid held high -> in_ready pulses on the last beat. Serial stream is 0000111111110000 across 16 consecutive cycles with no bubble.
- Flush: load 8'hFF, assert flush at bit_cnt=2 together with in_valid=1 -> next cycle ser_valid=0, IDLE, no word captured. A new load of 8'h01 then emits 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial sequencer: captures an 8-bit word and walks the
// 3-bit select across it, one bit per accepted serial beat.
module mux_scan_serializer #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] sel,
    output logic       ser_out,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_last,
    output logic       busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] held_q, held_d;
    logic [2:0] cnt_q, cnt_d;

    logic       shift;
    logic       last;
    logic       load;
    logic       beat;
    logic [2:0] sel_w;

    always_comb begin
        shift = (state_q == S_SHIFT);
        sel_w = LSB_FIRST ? cnt_q : (3'd7 - cnt_q);
        last  = shift & (cnt_q == 3'd7);
        // Reload window: idle, or the last beat is being taken right now.
        in_ready = ~flush & (~shift | (last & ser_ready));
        load  = in_valid & in_ready;
        beat  = shift & ser_ready;
    end

    assign sel       = sel_w;
    assign ser_out   = held_q[sel_w];
    assign ser_valid = shift;
    assign ser_last  = last;
    assign busy      = shift;

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
        end else if (load) begin
            state_d = S_SHIFT;
            held_d  = in_data;
            cnt_d   = 3'd0;
        end else if (beat) begin
            if (last) begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            held_q  <= 8'h00;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
